inst_fetch_queue: RTL and testbench

Instruction-fetch front end that drives the instruction memory's word-aligned byte address and buffers the returned words for decode. Holds the fetch PC and issues one address per cycle. Captures each combinationally returned instruction into a small prefetch FIFO tagged with its PC. Presents the FIFO head to decode through a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch at the new PC.

---
 rtl/inst_fetch_queue_if.sv | 41 ++++
 rtl/inst_fetch_queue.sv | 78 +++++++
 tb/tb_inst_fetch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory address/data, redirect request and the
// valid/ready decode handshake, with one modport for each side.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: drives the fetch PC, captures returned words into
// a small PC-tagged prefetch FIFO and hands them to decode; redirects flush it.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    inst_fetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_r;
    logic [63:0]   storage_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;

    // Handshake decode; a redirect suppresses both push and pop.
    always_comb begin
        empty_s = (count_r == {CW{1'b0}});
        full_s  = (count_r == CW'(DEPTH));
        pop_s   = ~empty_s & bus.out_ready & ~bus.redirect_valid;
        push_s  = ~bus.redirect_valid & (~full_s | pop_s);
    end

    // Fetch PC, pointers and occupancy; reset beats redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else if (bus.redirect_valid) begin
            // Masking keeps the target word-aligned regardless of the low bits.
            fetch_pc_r <= bus.redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r   <= wr_ptr_r + AW'(1);
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Entry storage, deliberately not cleared on reset.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            storage_r[wr_ptr_r] <= {fetch_pc_r, bus.imem_data};
        end
    end

    // Head presentation, zeroed while the queue is empty.
    always_comb begin
        bus.imem_addr = fetch_pc_r;
        bus.count     = count_r;
        bus.out_valid = ~empty_s;
        if (empty_s) begin
            bus.out_pc   = 32'h0000_0000;
            bus.out_inst = 32'h0000_0000;
        end else begin
            bus.out_pc   = storage_r[rd_ptr_r][63:32];
            bus.out_inst = storage_r[rd_ptr_r][31:0];
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: memory word at byte address a is
// 0x1000_0000 + a/4, and every expected value below is worked out by hand.
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    inst_fetch_queue_if #(.DEPTH(4)) bus ();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_pc"}, bus.out_pc, 32'h0);
        chk({tag, "_inst"}, bus.out_inst, 32'h0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        chk_empty("rst");
        chk("rst_addr", bus.imem_addr, 32'h0);

        // Streaming with out_ready high: one per cycle, count steady at 1.
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_pc", bus.out_pc, 32'(4 * i));
            chk("stream_inst", bus.out_inst, 32'h1000_0000 + 32'(i));
            chk("stream_count", 32'(bus.count), 32'd1);
        end

        // Reset mid-stream, then fill with out_ready low.
        reset = 1'b1;
        step();
        chk_empty("rst2");
        reset = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("fill_count", 32'(bus.count), (i < 4) ? 32'(i) : 32'd4);
            chk("fill_hold_pc", bus.out_pc, 32'h0);
        end
        chk("fill_addr", bus.imem_addr, 32'h10);
        chk("fill_inst", bus.out_inst, 32'h1000_0000);

        // Full FIFO, single simultaneous push/pop.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("fullpp_count", 32'(bus.count), 32'd4);
        chk("fullpp_pc", bus.out_pc, 32'h4);
        chk("fullpp_addr", bus.imem_addr, 32'h14);
        step();
        chk("fullpp_hold", bus.out_pc, 32'h4);

        // Drain in order with no gaps or repeats.
        bus.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("drain_pc", bus.out_pc, 32'h8 + 32'(4 * j));
            chk("drain_count", 32'(bus.count), 32'd4);
        end

        // Redirect while count = 3 and out_ready high.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        chk("pre_redir_count", 32'(bus.count), 32'd3);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        step();
        bus.redirect_valid = 1'b0;
        chk_empty("redir");
        chk("redir_addr", bus.imem_addr, 32'h200);
        step();
        chk("redir_pc", bus.out_pc, 32'h200);
        chk("redir_inst", bus.out_inst, 32'h1000_0080);
        step();
        chk("redir_pc2", bus.out_pc, 32'h204);

        // Redirect near the top of the address space; fetch PC wraps to 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_bubble", 32'(bus.out_valid), 32'd0);
        step();
        chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
        chk("wrap_inst0", bus.out_inst, 32'h4FFF_FFFE);
        step();
        chk("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_inst1", bus.out_inst, 32'h4FFF_FFFF);
        step();
        chk("wrap_pc2", bus.out_pc, 32'h0);
        chk("wrap_inst2", bus.out_inst, 32'h1000_0000);

        // Reset while full with a redirect pending: reset wins.
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        chk("full2_count", 32'(bus.count), 32'd4);
        reset              = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        step();
        chk_empty("rstred");
        chk("rstred_addr", bus.imem_addr, 32'h0);
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        chk("rstred_pc", bus.out_pc, 32'h0);
        chk("rstred_count", 32'(bus.count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
